// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  localparam int unsigned REG_W         = 5;
  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } hz_state_e;

endpackage : hazard_pkg

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the ID sources and the EX load destination.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs_id,
  input  logic [REG_W-1:0] i_rt_id,
  input  logic             i_uses_rs_id,
  input  logic             i_uses_rt_id,
  input  logic [REG_W-1:0] i_dest_reg_ex,
  input  logic             i_mem_read_ex,
  input  logic             i_reg_write_ex,
  output logic             o_load_use
);

  logic w_dest_live;
  logic w_rs_match;
  logic w_rt_match;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_dest_live = i_mem_read_ex & i_reg_write_ex & (i_dest_reg_ex != '0);
  assign w_rs_match  = i_uses_rs_id & (i_rs_id == i_dest_reg_ex);
  assign w_rt_match  = i_uses_rt_id & (i_rt_id == i_dest_reg_ex);
  assign o_load_use  = w_dest_live & (w_rs_match | w_rt_match);

endmodule : load_use_detect

// File: rtl/hazard_unit.sv
// Pipeline hazard control: freeze, redirect flush with a shadow cycle, load-use bubble,
// saturating event counters and a sticky memory-hang detector.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned HANG_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic [REG_W-1:0] DestReg_ex,
  input  logic             MemRead_ex,
  input  logic             RegWrite_ex,
  input  logic             redirect_ex,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_kill,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hang_err
);

  localparam int unsigned BusyW = (HANG_LIMIT < 2) ? 1 : $clog2(HANG_LIMIT + 1);
  localparam logic [BusyW-1:0] BusyMax = BusyW'(HANG_LIMIT);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [BusyW-1:0] r_busy_cnt;
  logic [BusyW-1:0] w_busy_nxt;
  logic             r_hang_err;

  logic w_lu_raw;
  logic w_freeze;
  logic w_redirect;
  logic w_lu;

  load_use_detect u_load_use_detect (
    .i_rs_id        (rs_id),
    .i_rt_id        (rt_id),
    .i_uses_rs_id   (uses_rs_id),
    .i_uses_rt_id   (uses_rt_id),
    .i_dest_reg_ex  (DestReg_ex),
    .i_mem_read_ex  (MemRead_ex),
    .i_reg_write_ex (RegWrite_ex),
    .o_load_use     (w_lu_raw)
  );

  // Priority: freeze > redirect/shadow > load-use > run.
  assign w_freeze   = mem_busy;
  assign w_redirect = ~w_freeze & (redirect_ex | (r_state == SHADOW));
  assign w_lu       = ~w_freeze & ~w_redirect & w_lu_raw;

  always_comb begin
    w_state_nxt = r_state;
    if (!w_freeze) begin
      // Every redirect is followed by a shadow cycle to squash the fetch already in flight.
      if (redirect_ex) begin
        w_state_nxt = SHADOW;
      end else begin
        w_state_nxt = RUN;
      end
    end
  end

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_we    = 1'b1;
    idex_kill  = 1'b0;
    if (!rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_we    = 1'b0;
      idex_kill  = 1'b1;
    end else if (w_freeze) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_we    = 1'b0;
    end else if (w_redirect) begin
      ifid_flush = 1'b1;
      idex_kill  = 1'b1;
    end else if (w_lu) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_kill  = 1'b1;
    end
  end

  always_comb begin
    w_busy_nxt = '0;
    if (mem_busy) begin
      w_busy_nxt = (r_busy_cnt == BusyMax) ? r_busy_cnt : r_busy_cnt + BusyW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lu && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_cnt <= '0;
      r_hang_err <= 1'b0;
    end else begin
      r_busy_cnt <= w_busy_nxt;
      if (w_busy_nxt == BusyMax) begin
        r_hang_err <= 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign hang_err  = r_hang_err;

endmodule : hazard_unit

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide parameter CNT_W, default 16: width of the saturating stall and flush event counters.
REQ-002 SHALL provide parameter HANG_LIMIT, default 255: consecutive mem_busy cycles tolerated before hang_err sets.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-004 rst input 1: asynchronous, active-low reset.
REQ-005 rs_id input 5: source register rs of the instruction in ID.
REQ-006 rt_id input 5: source register rt of the instruction in ID.
REQ-007 uses_rs_id / uses_rt_id input 1 each: the ID instruction reads rs / rt.
REQ-008 DestReg_ex input 5: destination register of the instruction in EX (ID/EX register output).
REQ-009 MemRead_ex, RegWrite_ex input 1 each: EX-stage control bits from the ID/EX register.
REQ-010 redirect_ex input 1: a taken branch, jump, jump-register or jump-and-link is resolved in EX this cycle.
REQ-011 mem_busy input 1: data memory is not ready, so the whole pipeline freezes.
REQ-012 pc_we output 1: PC write enable.
REQ-013 ifid_we output 1: IF/ID write enable.
REQ-014 ifid_flush output 1: IF/ID loads a NOP.
REQ-015 idex_we output 1: ID/EX write enable (drives its we).
REQ-016 idex_kill output 1: zeroes ID/EX side-effect controls (drives its kill_control).
REQ-017 stall_cnt, flush_cnt output CNT_W each: saturating event counters.
REQ-018 hang_err output 1: sticky flag set when memory is stuck.

Function
REQ-019 Load-use hazard (LU) SHALL be MemRead_ex & RegWrite_ex & (DestReg_ex != 0) & ((uses_rs_id & rs_id==DestReg_ex) | (uses_rt_id & rt_id==DestReg_ex)).
REQ-020 Priority SHALL be, highest first: FREEZE (mem_busy), REDIRECT (redirect_ex or state SHADOW), LU, RUN.
REQ-021 FREEZE: pc_we=ifid_we=idex_we=0, ifid_flush=idex_kill=0; the FSM state and pending redirect SHALL hold unchanged.
REQ-022 REDIRECT: pc_we=1, ifid_we=1, ifid_flush=1, idex_we=1, idex_kill=1, in the same cycle (zero latency).
REQ-023 LU: pc_we=0, ifid_we=0, idex_we=1, idex_kill=1, ifid_flush=0; exactly one bubble is inserted.
REQ-024 RUN: all three write enables =1, ifid_flush=idex_kill=0.
REQ-025 The FSM SHALL have states RUN and SHADOW.
REQ-026 RUN->SHADOW on redirect_ex with mem_busy=0. SHADOW->RUN after one non-frozen cycle.
REQ-027 In SHADOW the REDIRECT outputs SHALL be driven again, flushing the wrong-path instruction in flight from synchronous instruction memory.
REQ-028 redirect_ex asserted in SHADOW SHALL keep the FSM in SHADOW for one more cycle.
REQ-029 LU coincident with REDIRECT or SHADOW SHALL be ignored, because the ID instruction is wrong-path.
REQ-030 stall_cnt SHALL increment by 1 in each LU cycle, and flush_cnt in each REDIRECT cycle; both saturate at all-ones without wrapping.
REQ-031 A busy counter SHALL count consecutive mem_busy cycles and clear when mem_busy=0. When it reaches HANG_LIMIT, hang_err SHALL set and stay set until reset.
REQ-032 All control outputs SHALL be combinational from state and inputs. State, counters and hang_err SHALL be registered.

Reset
REQ-033 While rst=0: state=RUN, stall_cnt=flush_cnt=0, busy counter=0, hang_err=0; pc_we=ifid_we=idex_we=0, ifid_flush=idex_kill=1, asynchronously.
REQ-034 Reset asserted mid-SHADOW or mid-FREEZE SHALL abandon it. The first cycle after rst rises SHALL be RUN.

Structure
REQ-035 Package hazard_pkg SHALL hold the state enumeration (RUN, SHADOW), the register-index width 5, and the CNT_W default.
REQ-036 Sub-module load_use_detect (pure combinational LU compare) SHALL be instantiated once. The FSM, counters and output mux SHALL live in hazard_unit.

Verification
REQ-037 rs_id=5, uses_rs_id=1, DestReg_ex=5, MemRead_ex=RegWrite_ex=1 -> one cycle with pc_we=0, ifid_we=0, idex_kill=1; stall_cnt=1.
REQ-038 Same as REQ-037 with DestReg_ex=0 -> no stall, all write enables =1.
REQ-039 redirect_ex pulse for 1 cycle -> 2 consecutive cycles with ifid_flush=idex_kill=1 and pc_we=1; flush_cnt=2.
REQ-040 redirect_ex with LU in the same cycle -> REDIRECT outputs only; stall_cnt unchanged.
REQ-041 mem_busy for 3 cycles during SHADOW -> all write enables =0 for 3 cycles, then one SHADOW flush cycle, then RUN.
REQ-042 mem_busy held for 255 cycles -> hang_err=1 on cycle 255 and stays 1 after mem_busy drops; rst pulse clears it.
